// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x-oversampled UART receiver with first-word-fall-through receive FIFO
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse; default build is 8N1.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 en_16_x_baud,
    input  logic                 read_buffer,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 buffer_data_present,
    output logic                 buffer_half_full,
    output logic                 buffer_full,
    output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_BIT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   HALF_C   = (AW+1)'(FIFO_DEPTH / 2);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BRK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 push_req;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    assign rx_s = sync[1];

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], serial_in};
    end

    always_ff @(posedge clk) begin
        push_req      <= 1'b0;
        framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_error  <= 1'b0;
`endif
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else if (en_16_x_baud) begin
            case (state)
                IDLE: if (!rx_s) begin
                    state    <= START;
                    tick_cnt <= '0;
                end
                START: if (tick_cnt == HALF_BIT) begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= rx_s ? IDLE : DATA;
                end else tick_cnt <= tick_cnt + 1'b1;
                DATA: if (tick_cnt == FULL_BIT) begin
                    tick_cnt <= '0;
                    shift    <= {rx_s, shift[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end else bit_cnt <= bit_cnt + 1'b1;
                end else tick_cnt <= tick_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick_cnt == FULL_BIT) begin
                    tick_cnt <= '0;
                    par_bit  <= rx_s;
                    state    <= STOP;
                end else tick_cnt <= tick_cnt + 1'b1;
`endif
                STOP: if (tick_cnt == FULL_BIT) begin
                    tick_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift, par_bit}) parity_error <= 1'b1;
                        else                   push_req     <= 1'b1;
`else
                        push_req <= 1'b1;
`endif
                    end else begin
                        framing_error <= 1'b1;
                        state         <= BRK;
                    end
                end else tick_cnt <= tick_cnt + 1'b1;
                // A held-low line after a bad stop bit reports only once.
                BRK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] ram [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 do_push, do_pop;

    assign do_pop  = read_buffer && (count != '0);
    assign do_push = push_req && ((count != DEPTH_C) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) ram[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && !do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign buffer_data_present = (count != '0);
    assign buffer_half_full    = (count >= HALF_C);
    assign buffer_full         = (count == DEPTH_C);
    assign data_out            = buffer_data_present ? ram[rd_ptr] : '0;
endmodule
